// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Stall/flush sequencer for the 5-stage 16-bit pipeline. Produces write
// enables and bubble-inserts for the PC and the four pipeline registers from
// hazard, memory-busy and halt inputs, follows a HLT down the pipe to a
// terminal HALTED state, and keeps a watchdog on data-memory stalls.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous reset, active-low
//   id_hlt         in   HLT instruction in ID
//   wb_hlt         in   HLT has reached writeback (MEM/WB)
//   load_use       in   ID source depends on the load currently in EX
//   br_taken       in   branch/jump resolved taken in ID
//   imem_busy      in   instruction memory not ready
//   dmem_busy      in   data memory not ready for the MEM-stage access
//   pc_en .. memwb_en, ifid_flush, idex_flush
//                  out  Mealy stage controls (state + inputs), 0 during reset
//   halted         out  registered, core fully stopped
//   stall_cnt      out  consecutive dmem_busy cycles, saturating
//   stall_timeout  out  sticky, set when stall_cnt reaches MAX_STALL
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int CNT_W     = 8,
    parameter int MAX_STALL = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_hlt,
    input  logic             wb_hlt,
    input  logic             load_use,
    input  logic             br_taken,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_timeout
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DSTALL = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(MAX_STALL);

    state_t           state_q, state_d;
    logic             halted_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    logic pc_en_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s;
    logic exmem_en_s, memwb_en_s;

    // Next state and Mealy stage controls, in priority order
    always_comb begin
        state_d      = state_q;
        pc_en_s      = 1'b1;
        ifid_en_s    = 1'b1;
        ifid_flush_s = 1'b0;
        idex_en_s    = 1'b1;
        idex_flush_s = 1'b0;
        exmem_en_s   = 1'b1;
        memwb_en_s   = 1'b1;
        if (state_q == S_HALTED) begin
            pc_en_s    = 1'b0;
            ifid_en_s  = 1'b0;
            idex_en_s  = 1'b0;
            exmem_en_s = 1'b0;
            memwb_en_s = 1'b0;
        end else if (dmem_busy) begin
            // Full freeze; a drain in progress resumes once memory is ready
            pc_en_s    = 1'b0;
            ifid_en_s  = 1'b0;
            idex_en_s  = 1'b0;
            exmem_en_s = 1'b0;
            memwb_en_s = 1'b0;
            state_d    = (state_q == S_DRAIN) ? S_DRAIN : S_DSTALL;
        end else begin
            case (state_q)
                S_DRAIN: begin
                    // Keep fetching bubbles until the HLT retires
                    pc_en_s      = 1'b0;
                    ifid_flush_s = 1'b1;
                    state_d      = wb_hlt ? S_HALTED : S_DRAIN;
                end
                S_RUN, S_DSTALL: begin
                    state_d = S_RUN;
                    if (load_use) begin
                        pc_en_s      = 1'b0;
                        ifid_en_s    = 1'b0;
                        idex_flush_s = 1'b1;
                    end else if (br_taken) begin
                        // Redirect beats a pending fetch; the PC change abandons it
                        ifid_flush_s = 1'b1;
                    end else if (imem_busy) begin
                        pc_en_s      = 1'b0;
                        ifid_flush_s = 1'b1;
                    end else if (id_hlt) begin
                        pc_en_s      = 1'b0;
                        ifid_flush_s = 1'b1;
                        state_d      = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase
        end
    end

    // Stall counter next value and sticky watchdog
    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (dmem_busy) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_d == STALL_LIMIT) begin
                tmo_d = 1'b1;
            end else begin
                tmo_d = tmo_q;
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // State, halted flag and watchdog registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_RUN;
            halted_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == S_HALTED);
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
        end
    end

    // Stage controls are forced low while reset is asserted
    assign pc_en         = rst & pc_en_s;
    assign ifid_en       = rst & ifid_en_s;
    assign ifid_flush    = rst & ifid_flush_s;
    assign idex_en       = rst & idex_en_s;
    assign idex_flush    = rst & idex_flush_s;
    assign exmem_en      = rst & exmem_en_s;
    assign memwb_en      = rst & memwb_en_s;
    assign halted        = halted_q;
    assign stall_cnt     = cnt_q;
    assign stall_timeout = tmo_q;

endmodule
